// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back logic of the 5-stage MIPS core.
// Big-endian load alignment/extension, ALU-vs-load select, register-file
// write port back to ID, retired-instruction counter and misaligned-load flag.
module wb_stage #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               mem_valid,
    input  logic               mem_reg_write,
    input  logic               mem_mem_to_reg,
    input  logic [1:0]         mem_load_mode,
    input  logic [31:0]        mem_alu_result,
    input  logic [31:0]        mem_read_data,
    input  logic [4:0]         mem_dest_reg,
    output logic [5:0]         wb_write_register,
    output logic [31:0]        wb_write_data,
    output logic               wb_reg_write,
    output logic               wb_valid,
    output logic               wb_misaligned,
    output logic [COUNT_W-1:0] wb_retired_count
);

    localparam logic [1:0] LM_WORD  = 2'b00;
    localparam logic [1:0] LM_HALF  = 2'b01;
    localparam logic [1:0] LM_BYTE  = 2'b10;
    localparam logic [1:0] LM_BYTEU = 2'b11;

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    // Registered write-back state; every output is a direct flop copy.
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        misaligned;
        logic [4:0]  dest;
        logic [31:0] data;
    } wb_state_t;

    wb_state_t          st;
    logic [COUNT_W-1:0] retired;

    logic [1:0]  addr_lo;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] ld_data;
    logic        ld_mis;
    logic [31:0] wdata_d;
    logic        mis_d;
    logic        wen_d;

    assign addr_lo = mem_alu_result[1:0];

    // Big-endian lane select: low address bytes live in the high bits.
    always_comb begin
        half_sel = addr_lo[1] ? mem_read_data[15:0] : mem_read_data[31:16];
        case (addr_lo)
            2'b00:   byte_sel = mem_read_data[31:24];
            2'b01:   byte_sel = mem_read_data[23:16];
            2'b10:   byte_sel = mem_read_data[15:8];
            default: byte_sel = mem_read_data[7:0];
        endcase
    end

    // Extend the selected lane and detect misalignment per load mode.
    always_comb begin
        ld_data = mem_read_data;
        ld_mis  = 1'b0;
        case (mem_load_mode)
            LM_WORD: begin
                ld_data = mem_read_data;
                ld_mis  = (addr_lo != 2'b00);
            end
            LM_HALF: begin
                ld_data = {{16{half_sel[15]}}, half_sel};
                ld_mis  = addr_lo[0];
            end
            LM_BYTE:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            LM_BYTEU: ld_data = {24'h0, byte_sel};
            default:  ld_data = mem_read_data;
        endcase
    end

    // Write-back data select and write enable; $0 writes retire but never enable.
    always_comb begin
        wdata_d = mem_mem_to_reg ? ld_data : mem_alu_result;
        mis_d   = mem_valid & mem_mem_to_reg & ld_mis;
        wen_d   = mem_valid & mem_reg_write & ~mis_d & (mem_dest_reg != 5'd0);
    end

    // MEM/WB register: rst > flush > stall > load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= '0;
            retired <= '0;
        end else if (flush) begin
            st.valid      <= 1'b0;
            st.reg_write  <= 1'b0;
            st.misaligned <= 1'b0;
            st.dest       <= 5'd0;
        end else if (!stall) begin
            st.valid      <= mem_valid;
            st.reg_write  <= wen_d;
            st.misaligned <= mis_d;
            st.dest       <= mem_dest_reg;
            st.data       <= wdata_d;
            if (mem_valid)
                retired <= retired + CNT_ONE;
        end
    end

    assign wb_write_register = {1'b0, st.dest};
    assign wb_write_data     = st.data;
    assign wb_reg_write      = st.reg_write;
    assign wb_valid          = st.valid;
    assign wb_misaligned     = st.misaligned;
    assign wb_retired_count  = retired;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load alignment, write enables, stall/flush,
// async reset and counter wrap (second instance with a 4-bit counter).
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic        mem_valid, mem_reg_write, mem_mem_to_reg;
    logic [1:0]  mem_load_mode;
    logic [31:0] mem_alu_result, mem_read_data;
    logic [4:0]  mem_dest_reg;

    logic [5:0]  wb_write_register, s_write_register;
    logic [31:0] wb_write_data, s_write_data;
    logic        wb_reg_write, wb_valid, wb_misaligned;
    logic        s_reg_write, s_valid, s_misaligned;
    logic [31:0] wb_retired_count;
    logic [3:0]  s_retired_count;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    wb_stage #(.COUNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_load_mode(mem_load_mode),
        .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
        .mem_dest_reg(mem_dest_reg),
        .wb_write_register(wb_write_register), .wb_write_data(wb_write_data),
        .wb_reg_write(wb_reg_write), .wb_valid(wb_valid),
        .wb_misaligned(wb_misaligned), .wb_retired_count(wb_retired_count)
    );

    wb_stage #(.COUNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_load_mode(mem_load_mode),
        .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
        .mem_dest_reg(mem_dest_reg),
        .wb_write_register(s_write_register), .wb_write_data(s_write_data),
        .wb_reg_write(s_reg_write), .wb_valid(s_valid),
        .wb_misaligned(s_misaligned), .wb_retired_count(s_retired_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [1:0] mode, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [4:0] dest);
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_mem_to_reg = m2r;
        mem_load_mode  = mode;
        mem_alu_result = alu;
        mem_read_data  = rdata;
        mem_dest_reg   = dest;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'b00, 32'hDEADBEEF, 32'h0, 5'd7);
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({wb_write_register, wb_write_data, wb_reg_write, wb_valid, wb_misaligned} !== 41'd0) begin
            failures++;
            $display("FAIL reset_outputs: reg=%h data=%h we=%b v=%b mis=%b, required all 0",
                     wb_write_register, wb_write_data, wb_reg_write, wb_valid, wb_misaligned);
        end
        checks++;
        if (wb_retired_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d required 0", wb_retired_count);
        end
        checks++;
        if (s_retired_count !== 4'd0 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_small: count=%0d v=%b required 0/0", s_retired_count, s_valid);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        exp_cnt = 0;
    endtask

    task automatic test_lb();
        drive(1'b1, 1'b1, 1'b1, 2'b10, 32'h0000_1001, 32'h1180_3344, 5'd8);
        tick();
        exp_cnt++;
        checks++;
        if (wb_write_data !== 32'hFFFF_FF80) begin
            failures++;
            $display("FAIL lb_data: got %h required ffffff80", wb_write_data);
        end
        checks++;
        if (wb_write_register !== 6'd8 || wb_reg_write !== 1'b1 || wb_valid !== 1'b1 || wb_misaligned !== 1'b0) begin
            failures++;
            $display("FAIL lb_ctrl: reg=%0d we=%b v=%b mis=%b required 8/1/1/0",
                     wb_write_register, wb_reg_write, wb_valid, wb_misaligned);
        end
        checks++;
        if (wb_retired_count !== 32'(exp_cnt)) begin
            failures++;
            $display("FAIL lb_count: got %0d required %0d", wb_retired_count, exp_cnt);
        end
    endtask

    task automatic test_lbu_lh();
        drive(1'b1, 1'b1, 1'b1, 2'b11, 32'h0000_2003, 32'h0000_00F0, 5'd9);
        tick();
        exp_cnt++;
        checks++;
        if (wb_write_data !== 32'h0000_00F0 || wb_write_register !== 6'd9) begin
            failures++;
            $display("FAIL lbu: data=%h reg=%0d required 000000f0/9", wb_write_data, wb_write_register);
        end
        drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h0000_2002, 32'h1234_ABCD, 5'd10);
        tick();
        exp_cnt++;
        checks++;
        if (wb_write_data !== 32'hFFFF_ABCD || wb_reg_write !== 1'b1) begin
            failures++;
            $display("FAIL lh_low: data=%h we=%b required ffffabcd/1", wb_write_data, wb_reg_write);
        end
        drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h0000_2000, 32'h1234_ABCD, 5'd10);
        tick();
        exp_cnt++;
        checks++;
        if (wb_write_data !== 32'h0000_1234) begin
            failures++;
            $display("FAIL lh_high: data=%h required 00001234", wb_write_data);
        end
        drive(1'b1, 1'b1, 1'b1, 2'b11, 32'h0000_2001, 32'h1299_3344, 5'd11);
        tick();
        exp_cnt++;
        checks++;
        if (wb_write_data !== 32'h0000_0099) begin
            failures++;
            $display("FAIL lbu_b1: data=%h required 00000099", wb_write_data);
        end
        drive(1'b1, 1'b1, 1'b1, 2'b00, 32'h0000_2004, 32'hCAFE_F00D, 5'd12);
        tick();
        exp_cnt++;
        checks++;
        if (wb_write_data !== 32'hCAFE_F00D || wb_misaligned !== 1'b0 || wb_reg_write !== 1'b1) begin
            failures++;
            $display("FAIL lw: data=%h mis=%b we=%b required cafef00d/0/1", wb_write_data, wb_misaligned, wb_reg_write);
        end
        drive(1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_1233, 32'hFFFF_FFFF, 5'd13);
        tick();
        exp_cnt++;
        checks++;
        if (wb_write_data !== 32'h0000_1233 || wb_misaligned !== 1'b0) begin
            failures++;
            $display("FAIL alu_path: data=%h mis=%b required 00001233/0", wb_write_data, wb_misaligned);
        end
    endtask

    task automatic test_misaligned();
        drive(1'b1, 1'b1, 1'b1, 2'b00, 32'h0000_1002, 32'h1111_2222, 5'd4);
        tick();
        exp_cnt++;
        checks++;
        if (wb_misaligned !== 1'b1 || wb_reg_write !== 1'b0 || wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL lw_mis: mis=%b we=%b v=%b required 1/0/1", wb_misaligned, wb_reg_write, wb_valid);
        end
        checks++;
        if (wb_retired_count !== 32'(exp_cnt)) begin
            failures++;
            $display("FAIL mis_count: got %0d required %0d", wb_retired_count, exp_cnt);
        end
        drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h0000_1001, 32'h1111_2222, 5'd4);
        tick();
        exp_cnt++;
        checks++;
        if (wb_misaligned !== 1'b1 || wb_reg_write !== 1'b0) begin
            failures++;
            $display("FAIL lh_mis: mis=%b we=%b required 1/0", wb_misaligned, wb_reg_write);
        end
        drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_0055, 32'h0, 5'd0);
        tick();
        exp_cnt++;
        checks++;
        if (wb_reg_write !== 1'b0 || wb_valid !== 1'b1 || wb_misaligned !== 1'b0 || wb_write_register !== 6'd0) begin
            failures++;
            $display("FAIL rtype_r0: we=%b v=%b mis=%b reg=%0d required 0/1/0/0",
                     wb_reg_write, wb_valid, wb_misaligned, wb_write_register);
        end
        checks++;
        if (wb_retired_count !== 32'(exp_cnt)) begin
            failures++;
            $display("FAIL r0_count: got %0d required %0d", wb_retired_count, exp_cnt);
        end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_00AA, 32'h0, 5'd21);
        tick();
        exp_cnt++;
        stall = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 2'b10, 32'h0000_0003, 32'h0000_0081, 5'd22);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (wb_write_data !== 32'h0000_00AA || wb_write_register !== 6'd21 ||
                wb_reg_write !== 1'b1 || wb_valid !== 1'b1 || wb_retired_count !== 32'(exp_cnt)) begin
                failures++;
                $display("FAIL stall_hold[%0d]: data=%h reg=%0d we=%b v=%b cnt=%0d required 000000aa/21/1/1/%0d",
                         i, wb_write_data, wb_write_register, wb_reg_write, wb_valid, wb_retired_count, exp_cnt);
            end
        end
        flush = 1'b1;
        tick();
        checks++;
        if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || wb_misaligned !== 1'b0 ||
            wb_write_register !== 6'd0 || wb_retired_count !== 32'(exp_cnt)) begin
            failures++;
            $display("FAIL flush: v=%b we=%b mis=%b reg=%0d cnt=%0d required 0/0/0/0/%0d",
                     wb_valid, wb_reg_write, wb_misaligned, wb_write_register, wb_retired_count, exp_cnt);
        end
        flush = 1'b0;
        stall = 1'b0;
        tick();
        exp_cnt++;
        checks++;
        if (wb_write_data !== 32'hFFFF_FF81 || wb_valid !== 1'b1 || wb_retired_count !== 32'(exp_cnt)) begin
            failures++;
            $display("FAIL post_stall: data=%h v=%b cnt=%0d required ffffff81/1/%0d",
                     wb_write_data, wb_valid, wb_retired_count, exp_cnt);
        end
        drive(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0001, 32'h0, 5'd5);
        tick();
        checks++;
        if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || wb_retired_count !== 32'(exp_cnt)) begin
            failures++;
            $display("FAIL bubble: v=%b we=%b cnt=%0d required 0/0/%0d",
                     wb_valid, wb_reg_write, wb_retired_count, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_0777, 32'h0, 5'd3);
        tick();
        exp_cnt++;
        checks++;
        if (wb_reg_write !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst_we: got %b required 1", wb_reg_write);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({wb_write_register, wb_write_data, wb_reg_write, wb_valid, wb_misaligned} !== 41'd0 ||
            wb_retired_count !== 32'd0) begin
            failures++;
            $display("FAIL async_rst: reg=%h data=%h we=%b v=%b mis=%b cnt=%0d required all 0",
                     wb_write_register, wb_write_data, wb_reg_write, wb_valid, wb_misaligned, wb_retired_count);
        end
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 2'b00, 32'(i), 32'h0, 5'(i + 1));
            tick();
            exp_cnt++;
        end
        checks++;
        if (wb_retired_count !== 32'd4 || wb_write_data !== 32'd3 || wb_write_register !== 6'd4) begin
            failures++;
            $display("FAIL post_rst: cnt=%0d data=%h reg=%0d required 4/00000003/4",
                     wb_retired_count, wb_write_data, wb_write_register);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 5'd1);
        for (int k = 1; k <= 17; k++) begin
            tick();
            checks++;
            if (s_retired_count !== 4'(k % 16) || wb_retired_count !== 32'(k)) begin
                failures++;
                $display("FAIL wrap[%0d]: small=%0d wide=%0d required %0d/%0d",
                         k, s_retired_count, wb_retired_count, k % 16, k);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        test_reset();
        test_lb();
        test_lbu_lh();
        test_misaligned();
        test_stall_flush();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
